// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int          ITER_COUNT    = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/operand/result bundle between the CPU control path and muldiv_unit.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] ALUop1;
  logic [31:0] ALUop2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, ALUop1, ALUop2,
    input  busy, done, result
  );

  modport slave (
    input  start, op, ALUop1, ALUop2,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fix-up at the end.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// 64-bit product instead of the iterative path; divides are unchanged.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands, op and signs latched on accept
// CALC  | one iteration per cycle while counter runs 31..0, then a final
//       | cycle that applies sign fix-up / special cases into result
// DONE  | done pulse, result valid; returns to IDLE next cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam logic [4:0] CNT_INIT = 5'(ITER_COUNT - 1);

  state_t                 state_q, state_d;
  op_t                    op_q;
  logic [4:0]             cnt_q;
  logic                   fin_q;
  logic                   neg_a_q, neg_b_q, div0_q, ovf_q;
  logic [WIDTH-1:0]       b_mag_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]       result_q;

  op_t                    op_in;
  logic                   in_is_mul, sgn_a, sgn_b, neg_a, neg_b;
  logic [WIDTH-1:0]       a_mag, b_mag;

  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_nxt;
  logic [WIDTH:0]         div_shift;
  logic                   div_ge;
  logic [WIDTH-1:0]       div_diff;
  logic [2*WIDTH-1:0]     div_nxt;

  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       quo, rem, res_fix;

  assign op_in     = op_t'(bus.op);
  assign in_is_mul = ~bus.op[2];
  assign sgn_a     = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sgn_b     = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign neg_a     = sgn_a & bus.ALUop1[WIDTH-1];
  assign neg_b     = sgn_b & bus.ALUop2[WIDTH-1];
  assign a_mag     = cond_neg(bus.ALUop1, neg_a);
  assign b_mag     = cond_neg(bus.ALUop2, neg_b);

  // Multiply step: conditionally add multiplicand to the high half, shift right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: remainder in the high half, dividend/quotient in the low half.
  // A zero divisor just shifts the dividend into the remainder, so the
  // remainder ends up equal to the dividend magnitude.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_mag_q};
  assign div_diff  = div_shift[WIDTH-1:0] - b_mag_q;
  assign div_nxt   = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  // Final sign fix-up and special-case override, selected by the latched op.
  always_comb begin
    res_fix = '0;
    prod    = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
    quo     = cond_neg(acc_q[WIDTH-1:0], neg_a_q ^ neg_b_q);
    rem     = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_a_q);
    if (div0_q) begin
      quo = DIV0_QUOTIENT;
    end
    if (ovf_q) begin
      quo = INT_MIN;
      rem = '0;
    end
    case (op_q)
      OP_MUL:                       res_fix = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_fix = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              res_fix = quo;
      OP_REM, OP_REMU:              res_fix = rem;
      default:                      res_fix = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (fin_q)     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch on accept, iterate in CALC, write result on the final CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q    <= op_in;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            div0_q  <= ~in_is_mul & (bus.ALUop2 == '0);
            ovf_q   <= (op_in inside {OP_DIV, OP_REM}) &&
                       (bus.ALUop1 == INT_MIN) && (bus.ALUop2 == '1);
            cnt_q   <= CNT_INIT;
            fin_q   <= 1'b0;
            b_mag_q <= in_is_mul ? a_mag : b_mag;
            acc_q   <= {{WIDTH{1'b0}}, (in_is_mul ? b_mag : a_mag)};
`ifdef MULDIV_FAST_MUL_EN
            if (in_is_mul) begin
              acc_q <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
              fin_q <= 1'b1;
            end
`endif
          end
        end
        CALC: begin
          if (!fin_q) begin
            acc_q <= op_q[2] ? div_nxt : mul_nxt;
            if (cnt_q == '0) begin
              fin_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end else begin
            result_q <= res_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors with hand-computed
// results plus an arithmetic reference model checked every cycle.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    q  = 0;
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return (op[2] == 1'b0) ? (MUL_LAT + 1) : (DIV_LAT + 1);
  endfunction

  // Reference timeline: m_left counts edges until the unit is idle again.
  int          m_left   = 0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   <= 0;
      m_result <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 2) m_result <= m_pend;
    end else if (bus.start) begin
      m_pend <= ref_result(bus.op, bus.ALUop1, bus.ALUop2);
      m_left <= lat_of(bus.op);
    end
  end

  // Every-cycle comparison of DUT outputs against the reference.
  always @(negedge clk) begin
    if (!$isunknown(m_left) && $time > 5) begin
      checks++;
      if (bus.busy !== (m_left != 0)) begin
        errors++;
        $display("FAIL cmp_busy t=%0t actual=%b expected=%b", $time, bus.busy, (m_left != 0));
      end
      checks++;
      if (bus.done !== (m_left == 1)) begin
        errors++;
        $display("FAIL cmp_done t=%0t actual=%b expected=%b", $time, bus.done, (m_left == 1));
      end
      checks++;
      if (bus.result !== m_result) begin
        errors++;
        $display("FAIL cmp_result t=%0t actual=%h expected=%h", $time, bus.result, m_result);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.ALUop1 = a;
    bus.ALUop2 = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.op     = 3'($urandom);
    bus.ALUop1 = $urandom;
    bus.ALUop2 = $urandom;
  endtask

  task automatic wait_done(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic ok;
    launch(op, a, b);
    wait_done(lat, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s done_timeout actual=none expected=done", name);
    end else begin
      check(name, bus.result, exp);
      if (exp_lat > 0) check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic ok;
    int   pulses;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.ALUop1 = '0;
    bus.ALUop2 = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_result", bus.result,    32'd0);
    rst = 1'b0;

    run("mul_7_neg3",     OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run("mulhu_max",      OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run("mulh_intmin",    OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run("mulhsu_neg1_2",  OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
    run("div_neg20_3",    OP_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, DIV_LAT);
    run("rem_neg20_3",    OP_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, DIV_LAT);
    run("rem_20_neg3",    OP_REM,    32'd20,         32'hFFFF_FFFD, 32'd2,         0);
    run("divu_123_0",     OP_DIVU,   32'd123,        32'd0,         32'hFFFF_FFFF, DIV_LAT);
    run("remu_123_0",     OP_REMU,   32'd123,        32'd0,         32'd123,       0);
    run("div_neg20_0",    OP_DIV,    32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFFF, 0);
    run("rem_neg20_0",    OP_REM,    32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFEC, 0);
    run("div_ovf",        OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);
    run("rem_ovf",        OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
    run("divu_max_2",     OP_DIVU,   32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 0);

    // Second start during CALC must be ignored.
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = OP_DIVU;
    bus.ALUop1 = 32'd50;
    bus.ALUop2 = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ignore_start done_timeout actual=none expected=done");
    end else begin
      check("ignore_start", bus.result, 32'd14);
    end

    // Asynchronous reset in the middle of a divide.
    launch(OP_DIV, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",   32'(bus.busy), 32'd0);
    check("abort_done",   32'(bus.done), 32'd0);
    check("abort_result", bus.result,    32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run("mul_3_5_after_rst", OP_MUL, 32'd3, 32'd5, 32'd15, MUL_LAT);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
